// File: rtl/snn_spi_master.sv
// ---------------------------------------------------------------------------
// snn_spi_master
//   SPI (mode 0) command master for an SNN core. A command is one 16-bit
//   frame: address byte first, then data byte, both MSB-first.
//
//   Frame timing, with H = CLK_DIV clk cycles per SPI half-period:
//     SETUP 2H  : cs_n low, sck low, mosi = first bit
//     SHIFT 32H : 16 bits, each H cycles sck low then H cycles sck high
//     HOLD  2H  : cs_n low, sck low
//     GAP   2H  : cs_n high; done pulses on the first GAP cycle
//   So a command takes 38H cycles from acceptance until cmd_ready returns.
//
//   Optional feature macro: SNN_SPI_MASTER_READBACK_EN
//     When defined, spi_miso is sampled on the rising sck edges of the data
//     byte and presented on rd_data, with rd_valid pulsing alongside done.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command request
//   cmd_ready  out  idle, command can be accepted
//   cmd_addr   in   [7:0] register address byte
//   cmd_data   in   [7:0] register data byte
//   spi_clk    out  SPI clock, idle low
//   spi_cs_n   out  SPI chip select, active low
//   spi_mosi   out  serial data to the core
//   spi_miso   in   serial data from the core
//   done       out  one-cycle pulse at the end of a frame
//   rd_data    out  [7:0] read-back byte        (READBACK_EN only)
//   rd_valid   out  read-back strobe            (READBACK_EN only)
// ---------------------------------------------------------------------------
module snn_spi_master #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       spi_clk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso,
`ifdef SNN_SPI_MASTER_READBACK_EN
  output logic [7:0] rd_data,
  output logic       rd_valid,
`endif
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Last divider count of a half-period.
  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic        half_q, half_d;      // which half of the current 2H slot
  logic [7:0]  div_q, div_d;        // cycle within the current half
  logic [4:0]  bit_q, bit_d;        // frame bit index during SHIFT
  logic [15:0] shift_q, shift_d;    // outgoing word, bit 15 is on the wire
  logic        ready_q, ready_d;
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;
  logic        half_end;

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    half_end = (div_q == HALF_LAST);

    if (state_q == ST_IDLE) begin
      if (cmd_valid && ready_q) begin
        state_d = ST_SETUP;
        shift_d = {cmd_addr, cmd_data};
        div_d   = 8'd0;
        half_d  = 1'b0;
        bit_d   = 5'd0;
      end
    end else if (!half_end) begin
      div_d = div_q + 8'd1;
    end else begin
      div_d  = 8'd0;
      half_d = ~half_q;
      // Every non-idle state is a whole number of 2H slots; act only at
      // the end of the second half of a slot.
      if (half_q) begin
        case (state_q)
          ST_SETUP: state_d = ST_SHIFT;
          ST_SHIFT: begin
            // End of the sck-high half: advancing here makes mosi change
            // together with the falling sck edge.
            shift_d = {shift_q[14:0], 1'b0};
            if (bit_q == 5'd15) begin
              state_d = ST_HOLD;
              bit_d   = 5'd0;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
          ST_HOLD: begin
            state_d = ST_GAP;
            done_d  = 1'b1;
          end
          ST_GAP:  state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // Outputs are decoded from the next state so that they leave flops
    // aligned with the state register.
    ready_d = (state_d == ST_IDLE);
    sck_d   = (state_d == ST_SHIFT) && half_d;
    cs_n_d  = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
    mosi_d  = cs_n_d ? 1'b0 : shift_d[15];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      half_q  <= 1'b0;
      div_q   <= 8'd0;
      bit_q   <= 5'd0;
      shift_q <= 16'd0;
      ready_q <= 1'b0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = ready_q;
  assign spi_clk   = sck_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = mosi_q;
  assign done      = done_q;

`ifdef SNN_SPI_MASTER_READBACK_EN
  logic [7:0] rd_shift_q, rd_shift_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;

  always_comb begin
    rd_shift_d = rd_shift_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = done_d;
    // Sample on the clk edge that raises sck, for bits 8..15 (data byte).
    if ((state_q == ST_SHIFT) && !half_q && half_end && bit_q[3]) begin
      rd_shift_d = {rd_shift_q[6:0], spi_miso};
    end
    if (done_d) begin
      rd_data_d = rd_shift_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_shift_q <= 8'd0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_shift_q <= rd_shift_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
`endif

endmodule

// File: tb/tb_snn_spi_master.sv
// ---------------------------------------------------------------------------
// tb_snn_spi_master
//   Directed bench for snn_spi_master. Instance A runs at CLK_DIV=2, instance
//   B at CLK_DIV=1. Per-instance monitors reconstruct each frame from the
//   MOSI value seen at every rising SCK, and record cs_n-low length,
//   cs_n-high gap and done pulses. A also has a mode-0 slave model that
//   drives the byte in resp on MISO during the data byte.
// ---------------------------------------------------------------------------
module tb_snn_spi_master;

  localparam int H = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A (CLK_DIV = 2)
  logic       a_valid, a_ready, a_sck, a_cs_n, a_mosi, a_miso, a_done;
  logic [7:0] a_addr, a_data;
`ifdef SNN_SPI_MASTER_READBACK_EN
  logic [7:0] a_rd_data;
  logic       a_rd_valid;
`endif

  // Instance B (CLK_DIV = 1)
  logic       b_valid, b_ready, b_sck, b_cs_n, b_mosi, b_miso, b_done;
  logic [7:0] b_addr, b_data;
`ifdef SNN_SPI_MASTER_READBACK_EN
  logic [7:0] b_rd_data;
  logic       b_rd_valid;
`endif

  snn_spi_master #(.CLK_DIV(H)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_addr(a_addr), .cmd_data(a_data), .spi_clk(a_sck),
    .spi_cs_n(a_cs_n), .spi_mosi(a_mosi), .spi_miso(a_miso),
`ifdef SNN_SPI_MASTER_READBACK_EN
    .rd_data(a_rd_data), .rd_valid(a_rd_valid),
`endif
    .done(a_done)
  );

  snn_spi_master #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_addr(b_addr), .cmd_data(b_data), .spi_clk(b_sck),
    .spi_cs_n(b_cs_n), .spi_mosi(b_mosi), .spi_miso(b_miso),
`ifdef SNN_SPI_MASTER_READBACK_EN
    .rd_data(b_rd_data), .rd_valid(b_rd_valid),
`endif
    .done(b_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor A + slave model ----------------
  logic [15:0] a_frame, a_last_frame;
  logic [15:0] a_q[$];
  logic [7:0]  resp;
  int a_bits, a_last_bits, a_low_cnt, a_last_low, a_hi_cnt, a_gap;
  int a_frames, a_done_cnt, a_mosi_bad, a_rdv_bad;
  logic a_prev_sck, a_prev_cs;

  initial begin
    a_frame = 0; a_last_frame = 0; resp = 8'h00;
    a_bits = 0; a_last_bits = 0; a_low_cnt = 0; a_last_low = 0;
    a_hi_cnt = 0; a_gap = 0; a_frames = 0; a_done_cnt = 0;
    a_mosi_bad = 0; a_rdv_bad = 0; a_prev_sck = 0; a_prev_cs = 1;
    a_miso = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      a_bits = 0; a_frame = 0; a_low_cnt = 0; a_hi_cnt = 0;
      a_prev_sck = 0; a_prev_cs = 1; a_miso = 1'b0;
    end else begin
      if (a_cs_n && a_mosi) a_mosi_bad++;
      if (a_done) a_done_cnt++;
`ifdef SNN_SPI_MASTER_READBACK_EN
      if (a_rd_valid !== a_done) a_rdv_bad++;
`endif
      if (!a_cs_n) begin
        if (a_prev_cs) begin
          a_gap = a_hi_cnt; a_bits = 0; a_frame = 0; a_low_cnt = 0;
        end
        a_low_cnt++;
        if (a_sck && !a_prev_sck) begin
          a_frame = {a_frame[14:0], a_mosi};
          a_bits++;
        end
      end else begin
        if (!a_prev_cs) begin
          a_last_frame = a_frame; a_last_bits = a_bits; a_last_low = a_low_cnt;
          a_q.push_back(a_frame);
          a_frames++;
          a_hi_cnt = 0;
        end
        a_hi_cnt++;
      end
      // Next rising SCK carries frame bit a_bits; data byte is bits 8..15.
      a_miso = (!a_cs_n && a_bits >= 8 && a_bits < 16) ? resp[15 - a_bits] : 1'b0;
      a_prev_sck = a_sck;
      a_prev_cs  = a_cs_n;
    end
  end

  // ---------------- monitor B ----------------
  logic [15:0] b_frame, b_last_frame;
  int b_bits, b_last_bits, b_cyc, b_last_rise, b_per_min, b_per_max;
  logic b_prev_sck, b_prev_cs;

  initial begin
    b_frame = 0; b_last_frame = 0; b_bits = 0; b_last_bits = 0;
    b_cyc = 0; b_last_rise = 0; b_per_min = 999; b_per_max = 0;
    b_prev_sck = 0; b_prev_cs = 1;
  end

  always @(negedge clk) begin
    b_cyc++;
    if (!rst_n) begin
      b_bits = 0; b_frame = 0; b_prev_sck = 0; b_prev_cs = 1;
    end else begin
      if (!b_cs_n) begin
        if (b_prev_cs) begin b_bits = 0; b_frame = 0; end
        if (b_sck && !b_prev_sck) begin
          if (b_bits > 0) begin
            if (b_cyc - b_last_rise < b_per_min) b_per_min = b_cyc - b_last_rise;
            if (b_cyc - b_last_rise > b_per_max) b_per_max = b_cyc - b_last_rise;
          end
          b_last_rise = b_cyc;
          b_frame = {b_frame[14:0], b_mosi};
          b_bits++;
        end
      end else if (!b_prev_cs) begin
        b_last_frame = b_frame; b_last_bits = b_bits;
      end
      b_prev_sck = b_sck;
      b_prev_cs  = b_cs_n;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready_a(input string tag);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (a_ready) begin ok = 1; break; end
    end
    if (!ok) check(tag, 32'(ok), 32'd1);
  endtask

  task automatic send_a(input logic [7:0] ad, input logic [7:0] dt);
    wait_ready_a("a_ready_timeout");
    a_valid = 1'b1; a_addr = ad; a_data = dt;
    @(posedge clk);
    #1 a_valid = 1'b0;
  endtask

  // Cycles from the accepting edge to done and to cmd_ready.
  task automatic measure_a(output int done_at, output int ready_at);
    done_at = -1; ready_at = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_done && done_at < 0) done_at = n;
      if (a_ready) begin ready_at = n; break; end
    end
  endtask

  int d0, f0, done_at, ready_at;

  initial begin
    rst_n = 1'b0;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0; b_miso = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(a_cs_n), 32'd1);
    check("rst_sck", 32'(a_sck), 32'd0);
    check("rst_mosi", 32'(a_mosi), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_ready_low", 32'(a_ready), 32'd0);
`ifdef SNN_SPI_MASTER_READBACK_EN
    check("rst_rd_data", 32'(a_rd_data), 32'd0);
    check("rst_rd_valid", 32'(a_rd_valid), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_rst", 32'(a_ready), 32'd1);
    $display("txn reset: cs_n=%0b sck=%0b ready=%0b", a_cs_n, a_sck, a_ready);

    // ---- single write 0x00/0x32 ----
    d0 = a_done_cnt;
    send_a(8'h00, 8'h32);
    measure_a(done_at, ready_at);
    check("single_frame", 32'(a_last_frame), 32'h0032);
    check("single_bits", 32'(a_last_bits), 32'd16);
    check("single_cs_low", 32'(a_last_low), 32'd72);
    check("single_done_at", 32'(done_at), 32'd72);
    check("single_ready_at", 32'(ready_at), 32'd76);
    check("single_done_cnt", 32'(a_done_cnt - d0), 32'd1);
    $display("txn single: frame=%04h done_at=%0d ready_at=%0d", a_last_frame, done_at, ready_at);

    // ---- back-to-back with cmd_valid held ----
    d0 = a_done_cnt; f0 = a_frames;
    wait_ready_a("b2b_ready1");
    a_valid = 1'b1; a_addr = 8'h10; a_data = 8'h1E;
    @(posedge clk);
    #1 a_addr = 8'h11; a_data = 8'h14;
    wait_ready_a("b2b_ready2");
    @(posedge clk);
    #1 a_valid = 1'b0;
    wait_ready_a("b2b_ready3");
    check("b2b_frames", 32'(a_frames - f0), 32'd2);
    if (a_q.size() >= 2) check("b2b_frame1", 32'(a_q[a_q.size() - 2]), 32'h101E);
    check("b2b_frame2", 32'(a_last_frame), 32'h1114);
    check("b2b_gap_ok", 32'(a_gap >= 2 * H && a_gap <= 2 * H + 1), 32'd1);
    check("b2b_done_cnt", 32'(a_done_cnt - d0), 32'd2);
    $display("txn b2b: frames=%0d last=%04h gap=%0d", a_frames - f0, a_last_frame, a_gap);

    // ---- busy: cmd_valid pulse and addr change mid-frame ----
    d0 = a_done_cnt; f0 = a_frames;
    send_a(8'h02, 8'h0A);
    repeat (20) @(negedge clk);
    a_valid = 1'b1; a_addr = 8'hFF; a_data = 8'hFF;
    repeat (3) @(negedge clk);
    a_valid = 1'b0;
    wait_ready_a("busy_ready");
    repeat (10) @(negedge clk);
    check("busy_frame", 32'(a_last_frame), 32'h020A);
    check("busy_frames", 32'(a_frames - f0), 32'd1);
    check("busy_done_cnt", 32'(a_done_cnt - d0), 32'd1);
    $display("txn busy: frame=%04h frames=%0d", a_last_frame, a_frames - f0);

    // ---- async reset after the 5th SCK rise ----
    d0 = a_done_cnt; f0 = a_frames;
    send_a(8'h7E, 8'h81);
    begin
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (a_bits == 5) begin ok = 1; break; end
      end
      check("rst5_reach", 32'(ok), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst5_cs_n", 32'(a_cs_n), 32'd1);
    check("rst5_sck", 32'(a_sck), 32'd0);
    check("rst5_mosi", 32'(a_mosi), 32'd0);
    check("rst5_done", 32'(a_done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("rst5_no_done", 32'(a_done_cnt - d0), 32'd0);
    check("rst5_no_frame", 32'(a_frames - f0), 32'd0);
    send_a(8'h01, 8'h05);
    wait_ready_a("rst5_ready");
    check("rst5_next_frame", 32'(a_last_frame), 32'h0105);
    check("rst5_next_bits", 32'(a_last_bits), 32'd16);
    check("rst5_next_done", 32'(a_done_cnt - d0), 32'd1);
    $display("txn reset_mid: next frame=%04h", a_last_frame);

`ifdef SNN_SPI_MASTER_READBACK_EN
    // ---- read-back of 0xA5 during the data byte ----
    resp = 8'hA5;
    a_rdv_bad = 0;
    send_a(8'h80, 8'h00);
    begin
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (a_done) begin ok = 1; break; end
      end
      check("rb_done_seen", 32'(ok), 32'd1);
      check("rb_rd_valid", 32'(a_rd_valid), 32'd1);
      check("rb_rd_data", 32'(a_rd_data), 32'hA5);
    end
    wait_ready_a("rb_ready");
    check("rb_valid_coincident", 32'(a_rdv_bad), 32'd0);
    resp = 8'h00;
    $display("txn readback: rd_data=%02h", a_rd_data);
`endif

    // ---- CLK_DIV = 1 instance ----
    begin
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (b_ready) begin ok = 1; break; end
      end
      check("b_ready_idle", 32'(ok), 32'd1);
    end
    b_valid = 1'b1; b_addr = 8'h5A; b_data = 8'hC3;
    @(posedge clk);
    #1 b_valid = 1'b0;
    done_at = -1; ready_at = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (b_done && done_at < 0) done_at = n;
      if (b_ready) begin ready_at = n; break; end
    end
    check("div1_done_at", 32'(done_at), 32'd36);
    check("div1_latency", 32'(ready_at), 32'd38);
    check("div1_frame", 32'(b_last_frame), 32'h5AC3);
    check("div1_bits", 32'(b_last_bits), 32'd16);
    check("div1_per_min", 32'(b_per_min), 32'd2);
    check("div1_per_max", 32'(b_per_max), 32'd2);
    $display("txn div1: frame=%04h latency=%0d period=%0d", b_last_frame, ready_at, b_per_min);

    check("mosi_zero_when_idle", 32'(a_mosi_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
